wb_io_bank: RTL and testbench

- Parametrised Wishbone pipelined-slave I/O block that supersedes the single-register I/O slave model.
- Provides N_CH write channels and N_CH read channels, each one DW-bit word, with a fixed ack latency and a bounded number of outstanding requests enforced through stall.
- Returns a bus error for unmapped addresses.
- Sits on the J1 data bus as the simulation/peripheral I/O endpoint.

---
 rtl/wb_io_bank.sv | 130 +++++++++++++
 tb/tb_wb_io_bank.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wb_io_bank.sv
// wb_io_bank: Wishbone pipelined-slave I/O endpoint for the J1 data bus.
// Provides N_CH write channels and N_CH read channels of DW bits each. Every
// request terminates a fixed LATENCY edges after it is accepted, and stall
// limits the number of outstanding requests to MAX_OUT. Word addresses at or
// above N_CH terminate with err instead of ack.
//
// Ports:
//   clk, rst        bus clock (rising edge), asynchronous active-high reset
//   cyc, stb, we    Wishbone cycle, strobe and write enable
//   adr, dat_i      word address and write data
//   dat_o           read data, valid while ack=1 and held between read acks
//   ack, err        normal / error termination, one cycle each
//   stall           request not accepted this cycle
//   io_out          write-channel registers, channel k at [k*DW +: DW]
//   io_out_stb      one-cycle pulse per channel write
//   io_in           read-channel inputs, channel k at [k*DW +: DW]
//   io_in_rd        one-cycle pulse per channel read
module wb_io_bank #(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned MAX_OUT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc,
  input  logic              stb,
  input  logic              we,
  input  logic [AW-1:0]     adr,
  input  logic [DW-1:0]     dat_i,
  output logic [DW-1:0]     dat_o,
  output logic              ack,
  output logic              err,
  output logic              stall,
  output logic [N_CH*DW-1:0] io_out,
  output logic [N_CH-1:0]   io_out_stb,
  input  logic [N_CH*DW-1:0] io_in,
  output logic [N_CH-1:0]   io_in_rd
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } req_t;

  req_t             pipe_q [LATENCY];
  logic [LATENCY-1:0] vld_q;
  logic [CW-1:0]    count_q;

  logic             accept_c;
  logic             term_c;
  logic             mapped_c;
  req_t             head_c;
  logic [DW-1:0]    rd_data_c;

  // Stall depends only on the registered outstanding count.
  assign stall    = (count_q == CW'(MAX_OUT));
  assign accept_c = cyc & stb & ~stall;

  // Last pipeline stage terminates at the coming edge unless the cycle is dropped.
  assign head_c   = pipe_q[LATENCY-1];
  assign term_c   = cyc & vld_q[LATENCY-1];
  assign mapped_c = ({1'b0, head_c.adr} < (AW+1)'(N_CH));

  // Read-channel mux for the terminating request.
  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (head_c.adr == AW'(k)) rd_data_c = io_in[k*DW +: DW];
    end
  end

  // Request pipeline and outstanding count; a dropped cyc flushes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) pipe_q[i] <= '0;
    end else if (!cyc) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q[0]  <= accept_c;
      pipe_q[0] <= '{we: we, adr: adr, dat: dat_i};
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_q[i]  <= vld_q[i-1];
        pipe_q[i] <= pipe_q[i-1];
      end
      count_q <= count_q + CW'(accept_c) - CW'(term_c);
    end
  end

  // Termination: ack/err pulse, channel side effects and read data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack        <= 1'b0;
      err        <= 1'b0;
      dat_o      <= '0;
      io_out     <= '0;
      io_out_stb <= '0;
      io_in_rd   <= '0;
    end else begin
      ack        <= 1'b0;
      err        <= 1'b0;
      io_out_stb <= '0;
      io_in_rd   <= '0;
      if (term_c) begin
        if (!mapped_c) begin
          err <= 1'b1;
        end else begin
          ack <= 1'b1;
          if (head_c.we) begin
            for (int k = 0; k < int'(N_CH); k++) begin
              if (head_c.adr == AW'(k)) io_out[k*DW +: DW] <= head_c.dat;
            end
            io_out_stb <= N_CH'(1) << head_c.adr;
          end else begin
            dat_o    <= rd_data_c;
            io_in_rd <= N_CH'(1) << head_c.adr;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_io_bank.sv
// Randomized scoreboard bench for wb_io_bank, run on four latency/outstanding
// configurations in parallel against an in-bench transaction-level model.
module tb_wb_io_bank;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned N_CH = 4;
  localparam int unsigned IOW  = N_CH * DW;
  localparam int NCYC = 2000;

  typedef struct {
    int unsigned   due;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [DW-1:0] rdata;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input int c, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", c, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 3;
    localparam int unsigned M = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 1 : 2;

    logic           rst, cyc, stb, we;
    logic [AW-1:0]  adr;
    logic [DW-1:0]  dat_i, dat_o;
    logic           ack, err, stall;
    logic [IOW-1:0] io_out, io_in;
    logic [N_CH-1:0] io_out_stb, io_in_rd;
    bit             fin = 1'b0;

    item_t infl[$];
    item_t sb[$];

    wb_io_bank #(.DW(DW), .AW(AW), .N_CH(N_CH), .LATENCY(L), .MAX_OUT(M)) dut (
      .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
      .dat_i(dat_i), .dat_o(dat_o), .ack(ack), .err(err), .stall(stall),
      .io_out(io_out), .io_out_stb(io_out_stb), .io_in(io_in), .io_in_rd(io_in_rd)
    );

    task automatic chk_reset();
      check(g, "reset_outs", 64'({ack, err, io_out_stb, io_in_rd, dat_o}), 64'd0);
      check(g, "reset_io_out", 64'(io_out), 64'd0);
      check(g, "reset_stall", 64'(stall), 64'd0);
    endtask

    // Model the coming edge from the inputs currently driven.
    task automatic step();
      int unsigned n;
      bit acc;
      item_t it;
      logic [IOW-1:0] sh;
      n = edge_cnt + 1;
      acc = cyc && stb && (infl.size() < int'(M));
      if (!cyc) begin
        infl.delete();
      end else begin
        if (infl.size() > 0 && infl[0].due == n) begin
          it = infl.pop_front();
          sh = io_in >> (int'(it.adr) * DW);
          it.rdata = sh[DW-1:0];
          sb.push_back(it);
        end
        if (acc) begin
          it.due = n + L; it.we = we; it.adr = adr; it.dat = dat_i; it.rdata = '0;
          infl.push_back(it);
        end
      end
    endtask

    // Stimulus driver.
    initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; io_in = '0;
      @(negedge clk);
      chk_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NCYC; i++) begin
        @(negedge clk);
        if (i == 700 || i == 1300) begin
          #2 rst = 1'b1; cyc = 1'b0; stb = 1'b0;
          #1 chk_reset();
          infl.delete();
          sb.delete();
          @(negedge clk);
          rst = 1'b0;
          continue;
        end
        check(g, "stall", 64'(stall), 64'(infl.size() == int'(M)));
        cyc   = ($urandom % 100) >= 4;
        stb   = ($urandom % 4) != 0;
        we    = $urandom % 2;
        adr   = AW'($urandom % 6);
        dat_i = DW'($urandom);
        io_in = {$urandom, $urandom};
        step();
      end
      for (int i = 0; i < int'(L) + 2; i++) begin
        @(negedge clk);
        check(g, "drain_stall", 64'(stall), 64'(infl.size() == int'(M)));
        cyc = 1'b1; stb = 1'b0;
        io_in = {$urandom, $urandom};
        step();
      end
      @(negedge clk);
      check(g, "drain_empty", 64'(infl.size() + sb.size()), 64'd0);
      fin = 1'b1;
    end

    // Monitor: compare every post-edge output against the scoreboard.
    logic [IOW-1:0]  io_m  = '0;
    logic [DW-1:0]   dat_m = '0;
    always @(posedge clk) begin
      item_t it;
      logic [N_CH-1:0] stb_exp, rd_exp;
      bit mapped;
      #1;
      if (rst) begin
        io_m  = '0;
        dat_m = '0;
      end else begin
        stb_exp = '0;
        rd_exp  = '0;
        check(g, "ack_err_excl", 64'(ack & err), 64'd0);
        if (sb.size() > 0 && sb[0].due == edge_cnt) begin
          it = sb.pop_front();
          mapped = int'(it.adr) < int'(N_CH);
          check(g, "ack", 64'(ack), 64'(mapped));
          check(g, "err", 64'(err), 64'(!mapped));
          if (mapped && it.we) begin
            io_m = (io_m & ~(IOW'({DW{1'b1}}) << (int'(it.adr) * DW))) |
                   (IOW'(it.dat) << (int'(it.adr) * DW));
            stb_exp = N_CH'(1) << it.adr;
          end else if (mapped) begin
            dat_m  = it.rdata;
            rd_exp = N_CH'(1) << it.adr;
          end
        end else begin
          check(g, "idle_ack_err", 64'({ack, err}), 64'd0);
        end
        check(g, "io_out_stb", 64'(io_out_stb), 64'(stb_exp));
        check(g, "io_in_rd", 64'(io_in_rd), 64'(rd_exp));
        check(g, "dat_o", 64'(dat_o), 64'(dat_m));
        check(g, "io_out", 64'(io_out), 64'(io_m));
      end
    end
  end

  initial begin
    fork
      wait (cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin);
      #200000;
    join_any
    if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin)) begin
      checks++;
      errors++;
      $display("FAIL timeout: drivers did not complete");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
